chan_word_packer: RTL
=====================

Name: chan_word_packer

Overview:
- Sits directly downstream of the 80-channel round-robin selector. Consumes its per-cycle 387-bit word and 7-bit channel ID.
- Discards empty slots (all-zero words) and buffers non-empty words with their channel ID in a first-word-fall-through FIFO.
- Presents buffered words on a valid/ready stream to the next stage.
- Reports per-sweep statistics, overflow drops and channel-sequence errors. The upstream selector free-runs and has no backpressure, so overflow is handled by dropping.

Parameters:
- NUM_CH, 80, number of channels per sweep; channel IDs run 0..NUM_CH-1.
- DW, 387, data word width.
- CW, 7, channel ID width.
- DEPTH, 16, FIFO depth in entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  upstream is in run state; in_data/in_chid are meaningful this cycle
- in_data  in  DW  upstream word; all-zero means empty slot
- in_chid  in  CW  channel ID of in_data
- m_valid  out  1  output word available
- m_ready  in  1  downstream accepts the word
- m_data  out  DW  head-of-FIFO data
- m_chid  out  CW  head-of-FIFO channel ID
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- sweep_done  out  1  one-cycle pulse after a sweep ends
- sweep_count  out  8  non-empty words seen in the last completed sweep
- drop_count  out  16  words dropped because the FIFO was full
- seq_err  out  1  sticky channel-sequence error

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset:
  - FIFO is emptied; m_valid=0, m_data=0, m_chid=0, fifo_level=0.
  - sweep_done=0, sweep_count=0, drop_count=0, seq_err=0.
  - Internal sweep accumulator=0; sequence tracker disarmed.
  - A reset mid-operation discards all buffered words.
- Non-empty word: in_valid=1 and in_data != 0. A word with in_valid=0 is ignored entirely by every function.
- Storage: each entry holds {in_chid, in_data}. Pointers wrap modulo DEPTH; fifo_level counts 0..DEPTH.
- Output stream:
  - m_valid = (fifo_level != 0).
  - m_data/m_chid show the head entry, and show 0 when the FIFO is empty.
  - Pop occurs when m_valid && m_ready.
  - m_data/m_chid must hold stable while m_valid=1 and m_ready=0.
- Latency: a word pushed at edge N is visible on m_valid/m_data in cycle N+1. There is no same-cycle bypass.
- Push rule: a non-empty word is pushed if fifo_level < DEPTH, or if fifo_level == DEPTH and a pop occurs in the same cycle.
- Occupancy update:
  - Simultaneous push and pop leaves fifo_level unchanged.
  - At fifo_level==0, a push with m_ready=1 still pushes (no pop, since m_valid=0).
- Drop rule: a non-empty word that cannot be pushed increments drop_count. drop_count saturates at 16'hFFFF.
- Sweep accounting:
  - The accumulator counts non-empty words, whether pushed or dropped.
  - The sweep ends on a cycle with in_valid=1 and in_chid==NUM_CH-1.
  - At that edge, sweep_count <= accumulator plus the current word if it is non-empty, and the accumulator clears to 0.
  - sweep_done is high for exactly the next cycle.
  - The accumulator saturates at 255.
- Sequence check:
  - The first in_valid after reset arms the tracker, with expected = (in_chid+1) mod NUM_CH.
  - On each later in_valid cycle:
    - If in_chid != expected, seq_err is set and stays high until rst.
    - Expected then re-syncs to (in_chid+1) mod NUM_CH.
  - in_valid=0 cycles do not change the tracker.
  - in_chid >= NUM_CH always sets seq_err.
- Combinational outputs derive only from registered state; there are no combinational paths from in_* to m_*.

Test Plan:
- Reset, then 80 in_valid cycles with chid 0..79, words data=chid+1 (chid 0 word = 1), m_ready=1 -> 80 words out in order, each m_chid matching data-1; sweep_done pulses once, 1 cycle after the chid-79 input; sweep_count=80; drop_count=0; seq_err=0.
- Same sweep with data=0 on every even chid -> only 40 odd-chid words emitted; sweep_count=40.
- m_ready=0 for a full 80-word sweep, DEPTH=16 -> fifo_level=16, drop_count=64; after m_ready=1, exactly chids 0..15 drain in order.
- FIFO full (level 16) with m_ready=1 and a non-empty input on the same cycle -> push accepted, level stays 16, drop_count unchanged.
- chid sequence 0,1,2,5 -> seq_err rises in the cycle after chid 5 and stays 1 through a later correct sequence; rst clears it.
- Assert rst with 10 words buffered mid-sweep -> next cycle m_valid=0, fifo_level=0, counters 0; a new sweep from chid 0 produces sweep_count from fresh zero.

Source files
------------

// File: rtl/chan_word_packer.sv
// chan_word_packer
// ----------------
// Packs the free-running output of the round-robin channel selector into a
// valid/ready stream. Empty slots (all-zero words) are discarded. Non-empty
// words are stored together with their channel ID in a first-word-fall-through
// FIFO. Per-sweep statistics, overflow drops and channel-sequence errors are
// reported alongside.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   in_valid     upstream run state; in_data/in_chid meaningful this cycle
//   in_data      upstream word, all-zero = empty slot
//   in_chid      channel ID of in_data
//   m_valid      head-of-FIFO word available
//   m_ready      downstream accepts the head word
//   m_data       head data (0 while empty)
//   m_chid       head channel ID (0 while empty)
//   fifo_level   current occupancy, 0..DEPTH
//   sweep_done   one-cycle pulse after the last channel of a sweep
//   sweep_count  non-empty words seen in the last completed sweep (sat. 255)
//   drop_count   non-empty words lost to a full FIFO (sat. 16'hFFFF)
//   seq_err      sticky channel-sequence error
//
// Handshake: a word transfers on every rising clk edge where m_valid and
// m_ready are both high. m_valid never depends on m_ready, and m_data/m_chid
// hold steady while m_valid=1 and m_ready=0. The input side has no
// backpressure; words that cannot be stored are counted and dropped.
// All m_* outputs come from registered state only.

module chan_word_packer #(
   parameter int NUM_CH = 80,
   parameter int DW     = 387,
   parameter int CW     = 7,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [DW-1:0]            in_data,
   input  logic [CW-1:0]            in_chid,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DW-1:0]            m_data,
   output logic [CW-1:0]            m_chid,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     sweep_done,
   output logic [7:0]               sweep_count,
   output logic [15:0]              drop_count,
   output logic                     seq_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = CW + DW;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   // FIFO storage and pointers; DEPTH is a power of 2 so pointers wrap freely
   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [LW-1:0]  level;

   // sweep / sequence tracking state
   logic [7:0]     acc;
   logic           armed;
   logic [CW-1:0]  exp_ch;

   // per-cycle decisions
   logic           nonempty;
   logic           pop;
   logic           push;
   logic           drop;
   logic           sweep_end;
   logic           chid_bad;
   logic [7:0]     acc_inc;
   logic [CW-1:0]  exp_next;
   logic [EW-1:0]  head;

   always_comb begin
      nonempty  = in_valid && (in_data != '0);
      pop       = m_valid && m_ready;
      // at full, a pop in the same cycle frees the slot being written
      push      = nonempty && ((level != FULL_LVL) || pop);
      drop      = nonempty && !push;
      sweep_end = in_valid && (in_chid == CW'(NUM_CH - 1));
      chid_bad  = 32'(in_chid) >= 32'(NUM_CH);
      acc_inc   = (nonempty && (acc != 8'hFF)) ? acc + 8'd1 : acc;
      exp_next  = CW'((32'(in_chid) + 32'd1) % 32'(NUM_CH));
   end

   // outputs are masked to zero while empty so stale memory never leaks out
   assign head       = mem[rd_ptr];
   assign m_valid    = (level != '0);
   assign m_data     = m_valid ? head[DW-1:0]  : '0;
   assign m_chid     = m_valid ? head[EW-1:DW] : '0;
   assign fifo_level = level;

   // storage array is not reset; its contents are only visible via m_valid
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= {in_chid, in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         drop_count  <= '0;
         acc         <= '0;
         sweep_count <= '0;
         sweep_done  <= 1'b0;
         armed       <= 1'b0;
         exp_ch      <= '0;
         seq_err     <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end

         // the closing word of a sweep is counted into that sweep
         sweep_done <= sweep_end;
         if (sweep_end) begin
            sweep_count <= acc_inc;
            acc         <= '0;
         end else begin
            acc <= acc_inc;
         end

         // the first valid cycle only arms; later ones compare, then re-sync
         if (in_valid) begin
            armed  <= 1'b1;
            exp_ch <= exp_next;
            if (chid_bad || (armed && (in_chid != exp_ch))) begin
               seq_err <= 1'b1;
            end
         end
      end
   end

endmodule
